req_pending_latch: RTL

//  Upstream request stage for the 16-input priority encoder.
//  - Synchronises and debounces raw switch/key request lines.
//  - Latches each debounced rising edge as a sticky pending bit.
//  - Drives the pending vector straight into the encoder's encoder_in.
//  - Clears a bit when the downstream consumer services the encoded index,
//    so the encoder then reports the next-highest-priority request.

---
 rtl/req_pending_latch.sv | 108 ++++++++++
 1 files changed

// File: rtl/req_pending_latch.sv
// Request front end for the 16-input priority encoder: sync, debounce,
// latch debounced rising edges as sticky pending bits, clear on service.
// Ports: clock/reset_n (sync, active-low); raw_in raw request lines;
//   clr_valid/clr_idx service-clear strobe; ovf_clr clears overflow;
//   pending feeds encoder_in; any_pending = |pending; overflow is sticky.
module req_pending_latch #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int TICK_DIV = 50000,
  parameter int STABLE   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     raw_in,
  input  logic             clr_valid,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic             ovf_clr,
  output logic [N-1:0]     pending,
  output logic             any_pending,
  output logic             overflow
);

  // A 1-bit counter is kept for TICK_DIV=1 so the compare below still works;
  // it then sits at 0 and ticks every cycle.
  localparam int              CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [N-1:0]             sync1;
  logic [N-1:0]             sync2;
  logic [CNT_W-1:0]         tick_cnt;
  logic                     tick;
  logic [N-1:0][STABLE-1:0] hist;
  logic [N-1:0][STABLE-1:0] hist_nxt;
  logic [N-1:0]             level;
  logic [N-1:0]             level_nxt;
  logic [N-1:0]             level_d;
  logic [N-1:0]             rise;
  logic [N-1:0]             clr_mask;
  logic [N-1:0]             pend_nxt;
  logic                     ovf_set;

  assign tick = (tick_cnt == CNT_MAX);

  // Level update looks at the history including the sample taken this tick,
  // so a change is recognised on the tick that completes the stable run.
  always_comb begin
    hist_nxt  = hist;
    level_nxt = level;
    for (int i = 0; i < N; i++) begin
      hist_nxt[i] = {hist[i][STABLE-2:0], sync2[i]};
      if (tick) begin
        if (&hist_nxt[i]) begin
          level_nxt[i] = 1'b1;
        end else if (~|hist_nxt[i]) begin
          level_nxt[i] = 1'b0;
        end
      end
    end
  end

  assign rise = level & ~level_d;

  // Out-of-range indices simply match no bit.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      clr_mask[i] = clr_valid && (int'(clr_idx) == i);
    end
  end

  // Rise wins over a same-cycle clear: the serviced request is consumed and
  // the new one latched, so the bit stays set without flagging overflow.
  assign pend_nxt = (pending & ~clr_mask) | rise;
  assign ovf_set  = |(rise & pending & ~clr_mask);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1       <= '0;
      sync2       <= '0;
      tick_cnt    <= '0;
      hist        <= '0;
      level       <= '0;
      level_d     <= '0;
      pending     <= '0;
      any_pending <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      sync1   <= raw_in;
      sync2   <= sync1;
      if (tick) begin
        tick_cnt <= '0;
        hist     <= hist_nxt;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      level       <= level_nxt;
      level_d     <= level;
      pending     <= pend_nxt;
      any_pending <= |pend_nxt;
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
